// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Optional interrupt entry is compiled in with `define INTERRUPT_EN.
// No logic here; consumers import fetch_pkg::*.
package fetch_pkg;

  localparam int WORD_W = 16;

  localparam logic [31:0] DEF_RST_VEC_ADDR = 32'd0;
`ifdef INTERRUPT_EN
  localparam logic [31:0] DEF_INT_VEC_ADDR = 32'd2;
`endif

  typedef enum logic [2:0] {
    VEC_HI,
    VEC_LO,
    RUN,
    IMM
`ifdef INTERRUPT_EN
    ,
    INT_HI,
    INT_LO
`endif
  } fetch_state_t;

endpackage

// File: rtl/vector_loader.sv
// Assembles a 32-bit PC from two consecutive 16-bit memory words (high word first).
// Latency: high word registered on capture_hi, loaded_pc valid combinationally in the next cycle.
// No backpressure: the caller only pulses capture_hi in a vector-high state, which never stalls.
module vector_loader
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture_hi,
  input  logic [WORD_W-1:0] word,
  output logic [ADDR_W-1:0] loaded_pc
);

  logic [WORD_W-1:0] vec_hi_q;

  // Hold the high half of the vector until the low half arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_hi_q <= '0;
    end else if (capture_hi) begin
      vec_hi_q <= word;
    end
  end

  assign loaded_pc = ADDR_W'({vec_hi_q, word});

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, loads it from the reset vector, applies stall/redirect, flags immediates.
// Latency: combinational word presentation from pc_q; PC updates once per unstalled clock.
// Stall holds everything in RUN/IMM (never in vector load); redirect overrides stall. Optional INTERRUPT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                IMM_FLAG_BIT = 15,
  parameter logic [ADDR_W-1:0] RST_VEC_ADDR = ADDR_W'(DEF_RST_VEC_ADDR)
`ifdef INTERRUPT_EN
  ,
  parameter logic [ADDR_W-1:0] INT_VEC_ADDR = ADDR_W'(DEF_INT_VEC_ADDR)
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
`ifdef INTERRUPT_EN
  input  logic              irq,
  output logic [ADDR_W-1:0] epc,
`endif
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_data,
  output logic [WORD_W-1:0] instruction,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_pc,
  output logic              iam_bubble
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] loaded_pc;
  logic              capture_hi;
`ifdef INTERRUPT_EN
  logic [ADDR_W-1:0] epc_q, epc_d;
`endif

  assign pc_inc    = pc_q + ADDR_W'(1);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign next_pc   = pc_inc;
`ifdef INTERRUPT_EN
  assign epc       = epc_q;
`endif

  // Reset and interrupt entry both use the same HI/LO assembly.
  vector_loader #(
    .ADDR_W(ADDR_W)
  ) u_vector_loader (
    .clk       (clk),
    .rst       (rst),
    .capture_hi(capture_hi),
    .word      (imem_data),
    .loaded_pc (loaded_pc)
  );

  // State, PC and saved exception PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= VEC_HI;
      pc_q    <= RST_VEC_ADDR;
`ifdef INTERRUPT_EN
      epc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef INTERRUPT_EN
      epc_q   <= epc_d;
`endif
    end
  end

  // Next-state, next-PC and presented word; vector states emit bubbles and ignore stall/redirect.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    capture_hi  = 1'b0;
    instruction = '0;
    iam_bubble  = 1'b1;
`ifdef INTERRUPT_EN
    epc_d       = epc_q;
`endif
    case (state_q)
      VEC_HI: begin
        capture_hi = 1'b1;
        pc_d       = pc_inc;
        state_d    = VEC_LO;
      end
      VEC_LO: begin
        pc_d    = loaded_pc;
        state_d = RUN;
      end
      RUN: begin
        instruction = imem_data;
        iam_bubble  = 1'b0;
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = RUN;
        end else if (stall) begin
          pc_d    = pc_q;
          state_d = RUN;
`ifdef INTERRUPT_EN
        end else if (irq) begin
          // The current word is discarded and re-fetched after the handler returns to epc.
          instruction = '0;
          iam_bubble  = 1'b1;
          epc_d       = pc_q;
          pc_d        = INT_VEC_ADDR;
          state_d     = INT_HI;
`endif
        end else begin
          pc_d    = pc_inc;
          state_d = imem_data[IMM_FLAG_BIT] ? IMM : RUN;
        end
      end
      IMM: begin
        instruction = imem_data;
        iam_bubble  = 1'b1;
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = RUN;
        end else if (stall) begin
          pc_d    = pc_q;
          state_d = IMM;
        end else begin
          pc_d    = pc_inc;
          state_d = RUN;
        end
      end
`ifdef INTERRUPT_EN
      INT_HI: begin
        capture_hi = 1'b1;
        pc_d       = pc_inc;
        state_d    = INT_LO;
      end
      INT_LO: begin
        pc_d    = loaded_pc;
        state_d = RUN;
      end
`endif
      default: begin
        pc_d    = RST_VEC_ADDR;
        state_d = VEC_HI;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed stimulus, literal expectations and a stream-level model.
// The model tracks "vector words still to load", "next word is an immediate" and the PC.
// Build with INTERRUPT_EN defined to exercise interrupt entry as well.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instruction;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        iam_bubble;
`ifdef INTERRUPT_EN
  logic        irq;
  logic [31:0] epc;
`endif

  logic [15:0] mem [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[8'(imem_addr)];

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
`ifdef INTERRUPT_EN
    .irq        (irq),
    .epc        (epc),
`endif
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .instruction(instruction),
    .pc         (pc),
    .next_pc    (next_pc),
    .iam_bubble (iam_bubble)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] e_pc, input logic [15:0] e_ins,
                     input logic e_bub);
    check({name, ".pc"}, pc, e_pc);
    check({name, ".instr"}, {16'h0, instruction}, {16'h0, e_ins});
    check({name, ".bubble"}, {31'h0, iam_bubble}, {31'h0, e_bub});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  int          vec_left;   // vector words still to be read (2 = high word next)
  bit          in_imm;     // the word at m_pc is an immediate operand
  bit          m_valid = 1'b0;
  logic [31:0] m_pc;
  logic [15:0] m_hi;
  logic [31:0] m_epc;

  function automatic bit irq_taken();
`ifdef INTERRUPT_EN
    return (vec_left == 0) && !in_imm && irq && !stall && !redirect;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    logic [15:0] w;
    w = mem[8'(m_pc)];
    if (rst) begin
      vec_left = 2;
      in_imm   = 1'b0;
      m_pc     = 32'h0;
      m_epc    = 32'h0;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      if (vec_left == 2) begin
        m_hi     = w;
        m_pc     = m_pc + 32'd1;
        vec_left = 1;
      end else if (vec_left == 1) begin
        m_pc     = {m_hi, w};
        vec_left = 0;
      end else if (redirect) begin
        m_pc   = redirect_pc;
        in_imm = 1'b0;
      end else if (stall) begin
        m_pc = m_pc;
      end else if (irq_taken()) begin
        m_epc    = m_pc;
        m_pc     = 32'd2;
        vec_left = 2;
      end else if (in_imm) begin
        m_pc   = m_pc + 32'd1;
        in_imm = 1'b0;
      end else begin
        in_imm = w[15];
        m_pc   = m_pc + 32'd1;
      end
    end
  end

  // Compare every cycle once the model has seen reset.
  always @(negedge clk) begin
    logic [15:0] w, e_ins;
    logic        e_bub;
    if (m_valid) begin
      w = mem[8'(m_pc)];
      if (vec_left > 0 || irq_taken()) begin
        e_ins = 16'h0;
        e_bub = 1'b1;
      end else begin
        e_ins = w;
        e_bub = in_imm;
      end
      check("model.pc", pc, m_pc);
      check("model.next_pc", next_pc, m_pc + 32'd1);
      check("model.imem_addr", imem_addr, m_pc);
      check("model.instr", {16'h0, instruction}, {16'h0, e_ins});
      check("model.bubble", {31'h0, iam_bubble}, {31'h0, e_bub});
`ifdef INTERRUPT_EN
      check("model.epc", epc, m_epc);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h0000; mem[8'h01] = 16'h0010;
    mem[8'h02] = 16'h0000; mem[8'h03] = 16'h0080;
    mem[8'h10] = 16'h8123; mem[8'h11] = 16'hBEEF;
    mem[8'h12] = 16'h0001; mem[8'h13] = 16'h0002;
    mem[8'h14] = 16'h8005; mem[8'h15] = 16'h1234;
    mem[8'h20] = 16'h8777; mem[8'h21] = 16'h5555;
    mem[8'h30] = 16'h0030; mem[8'h40] = 16'h0040;
    mem[8'h80] = 16'h0080; mem[8'hFF] = 16'h0007;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
`ifdef INTERRUPT_EN
    irq = 1'b0;
`endif
    repeat (2) tick();
    lit("reset", 32'h0, 16'h0, 1'b1);
    check("reset.next_pc", next_pc, 32'h1);

    // Vector load, then a flagged instruction followed by its immediate.
    rst = 1'b0;
    tick(); lit("vec_lo", 32'h1, 16'h0, 1'b1);
    tick(); lit("first_instr", 32'h10, 16'h8123, 1'b0);
    tick(); lit("imm_word", 32'h11, 16'hBEEF, 1'b1);
    tick(); lit("after_imm", 32'h12, 16'h0001, 1'b0);

    // Stall holds the PC and presented word.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); lit("stall_hold", 32'h12, 16'h0001, 1'b0);
    end
    stall = 1'b0;
    tick(); lit("unstall", 32'h13, 16'h0002, 1'b0);
    tick(); lit("flag2", 32'h14, 16'h8005, 1'b0);
    tick(); lit("imm2", 32'h15, 16'h1234, 1'b1);

    // Redirect with stall in IMM: redirect wins, immediate discarded.
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    tick(); lit("redir_imm", 32'h40, 16'h0040, 1'b0);

    // PC wrap at the top of the address space.
    stall = 1'b0; redirect_pc = 32'hFFFF_FFFF;
    tick(); lit("wrap_top", 32'hFFFF_FFFF, 16'h0007, 1'b0);
    check("wrap_next_pc", next_pc, 32'h0);
    redirect = 1'b0;
    tick(); lit("wrapped", 32'h0, 16'h0000, 1'b0);

    // Reset while presenting an immediate restarts the vector load.
    redirect = 1'b1; redirect_pc = 32'h20;
    tick(); lit("to_0x20", 32'h20, 16'h8777, 1'b0);
    redirect = 1'b0;
    tick(); lit("imm3", 32'h21, 16'h5555, 1'b1);
    rst = 1'b1;
    tick(); lit("rst_in_imm", 32'h0, 16'h0, 1'b1);

    // Redirect and stall are both ignored during vector load.
    rst = 1'b0; redirect = 1'b1; redirect_pc = 32'h99;
    tick(); lit("vec_ign_redir", 32'h1, 16'h0, 1'b1);
    redirect = 1'b0; stall = 1'b1;
    tick(); lit("vec_ign_stall", 32'h10, 16'h8123, 1'b0);
    stall = 1'b0;
    tick(); lit("reload_imm", 32'h11, 16'hBEEF, 1'b1);
    tick(); lit("reload_run", 32'h12, 16'h0001, 1'b0);

`ifdef INTERRUPT_EN
    // Interrupt entry from RUN at 0x30.
    redirect = 1'b1; redirect_pc = 32'h30;
    tick();
    redirect = 1'b0; irq = 1'b1;
    #1;
    lit("irq_force", 32'h30, 16'h0, 1'b1);
    tick();
    irq = 1'b0;
    lit("int_hi", 32'h2, 16'h0, 1'b1);
    check("epc", epc, 32'h30);
    tick(); lit("int_lo", 32'h3, 16'h0, 1'b1);
    tick(); lit("handler", 32'h80, 16'h0080, 1'b0);
`endif

    repeat (4) tick();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
